// File: rtl/rv_mem_pkg.sv
// Shared load/store definitions: RV32 funct3 size codes, LSU state encoding and a legality helper.
package rv_mem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      RESP  = 2'd3
   } lsu_state_e;

   // Stores have no unsigned variants; loads accept all five size codes.
   function automatic logic funct3_legal(input logic is_store, input logic [2:0] f3);
      logic legal;
      legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      if (!is_store) legal = legal || (f3 == F3_BU) || (f3 == F3_HU);
      return legal;
   endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// Core request/response channels plus the word-granular data-memory port.
interface lsu_mem_master_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_is_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;

   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_error;

   logic [31:0] mem_address;
   logic [31:0] mem_write_data;
   logic        mem_write_enable;
   logic        mem_read_enable;
   logic [31:0] mem_read_data;

   modport master (
      input  req_valid, req_is_store, req_funct3, req_addr, req_wdata,
      input  resp_ready, mem_read_data,
      output req_ready, resp_valid, resp_rdata, resp_error,
      output mem_address, mem_write_data, mem_write_enable, mem_read_enable
   );

   modport slave (
      output req_valid, req_is_store, req_funct3, req_addr, req_wdata,
      output resp_ready, mem_read_data,
      input  req_ready, resp_valid, resp_rdata, resp_error,
      input  mem_address, mem_write_data, mem_write_enable, mem_read_enable
   );

endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane alignment: extracts/extends load data and merges sub-word store data into a word.
module lsu_lane_align
   import rv_mem_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  lane,
   input  logic [31:0] rdata,
   input  logic [15:0] wdata,
   output logic [31:0] load_data_c,
   output logic [31:0] store_word_c
);

   logic [4:0]  byte_sh;
   logic [4:0]  half_sh;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] mask;

   always_comb begin
      byte_sh      = {lane, 3'b000};
      half_sh      = {lane[1], 4'b0000};
      byte_sel     = 8'(rdata >> byte_sh);
      half_sel     = 16'(rdata >> half_sh);
      load_data_c  = rdata;
      store_word_c = rdata;
      mask         = 32'h0000_0000;

      case (funct3)
         F3_B:    load_data_c = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   load_data_c = {24'h00_0000, byte_sel};
         F3_H:    load_data_c = {{16{half_sel[15]}}, half_sel};
         F3_HU:   load_data_c = {16'h0000, half_sel};
         default: load_data_c = rdata;
      endcase

      // Only SB/SH reach the merge path; the halfword lane is chosen by addr[1].
      if (funct3 == F3_B) begin
         mask         = 32'h0000_00FF << byte_sh;
         store_word_c = (rdata & ~mask) | ((32'(wdata[7:0]) << byte_sh) & mask);
      end else begin
         mask         = 32'h0000_FFFF << half_sh;
         store_word_c = (rdata & ~mask) | ((32'(wdata) << half_sh) & mask);
      end
   end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator: turns byte-addressed core requests into word accesses, with
// read-modify-write for sub-word stores and a held response channel.
module lsu_mem_master
   import rv_mem_pkg::*;
#(
   parameter int unsigned MEM_WORDS = 512,
   parameter int unsigned IDX_W     = $clog2(MEM_WORDS)
) (
   input logic               clk,
   input logic               reset,
   lsu_mem_master_if.master  bus
);

   lsu_state_e  state;
   logic        is_store_q;
   logic [2:0]  funct3_q;
   logic [1:0]  lane_q;
   logic [15:0] wdata_q;
   logic [31:0] load_data_c;
   logic [31:0] store_word_c;
   logic        req_err_c;

   lsu_lane_align u_align (
      .funct3       (funct3_q),
      .lane         (lane_q),
      .rdata        (bus.mem_read_data),
      .wdata        (wdata_q),
      .load_data_c  (load_data_c),
      .store_word_c (store_word_c)
   );

   // Request screening: illegal size code, misalignment, or address beyond the memory.
   always_comb begin
      req_err_c = !funct3_legal(bus.req_is_store, bus.req_funct3);
      if (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0])          req_err_c = 1'b1;
      if (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00) req_err_c = 1'b1;
      if (bus.req_addr[31:IDX_W+2] != '0)                            req_err_c = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state                <= IDLE;
         is_store_q           <= 1'b0;
         funct3_q             <= 3'b000;
         lane_q               <= 2'b00;
         wdata_q              <= 16'h0000;
         bus.req_ready        <= 1'b1;
         bus.resp_valid       <= 1'b0;
         bus.resp_rdata       <= 32'h0000_0000;
         bus.resp_error       <= 1'b0;
         bus.mem_address      <= 32'h0000_0000;
         bus.mem_write_data   <= 32'h0000_0000;
         bus.mem_write_enable <= 1'b0;
         bus.mem_read_enable  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  is_store_q      <= bus.req_is_store;
                  funct3_q        <= bus.req_funct3;
                  lane_q          <= bus.req_addr[1:0];
                  wdata_q         <= bus.req_wdata[15:0];
                  bus.mem_address <= 32'(bus.req_addr[IDX_W+1:2]);
                  bus.req_ready   <= 1'b0;
                  if (req_err_c) begin
                     bus.resp_valid <= 1'b1;
                     bus.resp_error <= 1'b1;
                     bus.resp_rdata <= 32'h0000_0000;
                     state          <= RESP;
                  end else if (bus.req_is_store && bus.req_funct3 == F3_W) begin
                     bus.mem_write_data   <= bus.req_wdata;
                     bus.mem_write_enable <= 1'b1;
                     state                <= WRITE;
                  end else begin
                     bus.mem_read_enable <= 1'b1;
                     state               <= READ;
                  end
               end
            end
            READ: begin
               bus.mem_read_enable <= 1'b0;
               if (is_store_q) begin
                  bus.mem_write_data   <= store_word_c;
                  bus.mem_write_enable <= 1'b1;
                  state                <= WRITE;
               end else begin
                  bus.resp_rdata <= load_data_c;
                  bus.resp_error <= 1'b0;
                  bus.resp_valid <= 1'b1;
                  state          <= RESP;
               end
            end
            WRITE: begin
               bus.mem_write_enable <= 1'b0;
               bus.resp_rdata       <= 32'h0000_0000;
               bus.resp_error       <= 1'b0;
               bus.resp_valid       <= 1'b1;
               state                <= RESP;
            end
            RESP: begin
               if (bus.resp_ready) begin
                  bus.resp_valid <= 1'b0;
                  bus.req_ready  <= 1'b1;
                  state          <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
